si_tag_lane_serializer: RTL

// Sits downstream of the multi-lane tag converter (NUMBER_OF_WORDS tags/beat plus keep mask).

---
 rtl/si_tag_pkg.sv | 47 ++++
 rtl/si_lane_priority_enc.sv | 39 +++
 rtl/si_tag_lane_serializer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/si_tag_pkg.sv
// ============================================================================
//  Module      : si_tag_pkg
//  Description : Shared types and helpers for the tag lane serializer.
//                tag_t is one time-tagged event (64-bit time in 1/3 ps and a
//                signed channel: +c rising edge, -c falling edge).
//                chan_to_en_bit maps a signed channel onto its bit position in
//                the channel-enable mask and reports whether it is in range.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package si_tag_pkg;

  typedef struct packed {
    logic [63:0]        tagtime;
    logic signed [5:0]  channel;
  } tag_t;

  typedef struct packed {
    logic [6:0] idx;       // bit position inside the 2*CC enable mask
    logic       in_range;  // 0 for channel 0 or |channel| > CC
  } en_bit_t;

  // Rising channels +1..+CC occupy bits 0..CC-1; falling channels -1..-CC
  // occupy bits CC..2*CC-1.
  function automatic en_bit_t chan_to_en_bit(input logic signed [5:0] channel,
                                             input int                cc);
    en_bit_t r;
    int      c;
    int      t;
    r = '0;
    t = 0;
    c = int'(channel);
    if (c > 0 && c <= cc) begin
      t          = c - 1;
      r.in_range = 1'b1;
    end else if (c < 0 && -c <= cc) begin
      t          = cc - c - 1;
      r.in_range = 1'b1;
    end
    r.idx = t[6:0];
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/si_lane_priority_enc.sv
// ============================================================================
//  Module      : si_lane_priority_enc
//  Description : Lowest-set-bit priority encoder over the pending lane mask.
//  Ports       : pend_i    - pending lane mask
//                onehot_o  - one-hot of the lowest pending lane
//                idx_o     - binary index of the lowest pending lane
//                is_last_o - exactly one lane pending
//                any_o     - at least one lane pending
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module si_lane_priority_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     pend_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             is_last_o,
  output logic             any_o
);

  always_comb begin
    // Two's-complement trick isolates the lowest set bit.
    onehot_o = pend_i & (~pend_i + N'(1));
    idx_o    = '0;
    // Scan downwards so the lowest set bit is the one that sticks.
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_i[i]) idx_o = IDX_W'(i);
    end
    any_o     = |pend_i;
    // Clearing the lowest bit leaves nothing iff popcount is one.
    is_last_o = any_o && ((pend_i & (pend_i - N'(1))) == '0);
  end

endmodule

`default_nettype wire

// File: rtl/si_tag_lane_serializer.sv
// ============================================================================
//  Module      : si_tag_lane_serializer
//  Description : Serializes the kept, channel-enabled lanes of a multi-lane
//                tag beat onto a one-tag-per-cycle AXI-Stream, ascending lane
//                order within a beat, beats in arrival order.
//                Stage H holds the accepted beat plus a pending-lane mask;
//                stage O is the registered output.
//  Ports       : clk, rst_n (synchronous, active low)
//                s_axis_*  - multi-lane input beat (tagtime, channel, tkeep)
//                m_axis_*  - single tag output with tlast on the last tag
//                            emitted from each beat
//                cfg_channel_enable - bit c-1 enables +c, bit CC+c-1 enables -c
//                stat_tags_out / stat_tags_filtered - only when the macro
//                SI_TAG_SERIALIZER_STATS_EN is defined
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module si_tag_lane_serializer
  import si_tag_pkg::*;
#(
  parameter int NUMBER_OF_WORDS = 4,
  parameter int CHANNEL_COUNT   = 20
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [NUMBER_OF_WORDS-1:0][63:0]  s_axis_tagtime,
  input  logic [NUMBER_OF_WORDS-1:0][5:0]   s_axis_channel,
  input  logic [NUMBER_OF_WORDS-1:0]        s_axis_tkeep,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [63:0]                       m_axis_tagtime,
  output logic signed [5:0]                 m_axis_channel,
  output logic                              m_axis_tlast,
  input  logic [2*CHANNEL_COUNT-1:0]        cfg_channel_enable
`ifdef SI_TAG_SERIALIZER_STATS_EN
  ,
  output logic [63:0]                       stat_tags_out,
  output logic [31:0]                       stat_tags_filtered
`endif
);

  localparam int N     = NUMBER_OF_WORDS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  function automatic logic [31:0] f_popcount(input logic [N-1:0] v);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + {31'd0, v[i]};
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Per-lane channel filter on the incoming beat
  // --------------------------------------------------------------------------
  logic [N-1:0] w_lane_en;
  tag_t [N-1:0] w_beat;

  for (genvar l = 0; l < N; l++) begin : g_lane
    en_bit_t                    w_eb;
    logic [2*CHANNEL_COUNT-1:0] w_sh;
    assign w_eb               = chan_to_en_bit(s_axis_channel[l], CHANNEL_COUNT);
    assign w_sh               = cfg_channel_enable >> w_eb.idx;
    assign w_lane_en[l]       = w_eb.in_range & w_sh[0];
    assign w_beat[l].tagtime  = s_axis_tagtime[l];
    assign w_beat[l].channel  = s_axis_channel[l];
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  tag_t [N-1:0] hold_q, hold_d;
  logic [N-1:0] pend_q, pend_d;
  tag_t         out_q, out_d;
  logic         out_vld_q, out_vld_d;
  logic         out_last_q, out_last_d;

  logic [N-1:0]     w_onehot;
  logic [IDX_W-1:0] w_idx;
  logic             w_is_last;
  logic             w_any;

  si_lane_priority_enc #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_prio (
    .pend_i    (pend_q),
    .onehot_o  (w_onehot),
    .idx_o     (w_idx),
    .is_last_o (w_is_last),
    .any_o     (w_any)
  );

  logic w_o_load;
  logic w_accept;

  // O can take a new value when it is empty or its current tag is leaving.
  assign w_o_load      = !out_vld_q || m_axis_tready;
  // Accept when H is empty, or when its last pending lane moves to O this
  // cycle, so back-to-back beats stream without a bubble.
  assign s_axis_tready = rst_n && (!w_any || (w_is_last && w_o_load));
  assign w_accept      = s_axis_tvalid && s_axis_tready;

  always_comb begin
    hold_d     = hold_q;
    pend_d     = pend_q;
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;

    if (w_o_load) begin
      if (w_any) begin
        out_d      = hold_q[w_idx];
        out_vld_d  = 1'b1;
        out_last_d = w_is_last;
        pend_d     = pend_q & ~w_onehot;
      end else begin
        out_vld_d  = 1'b0;
      end
    end

    // Acceptance only happens once the old mask is (about to be) empty, so
    // overwriting the mask here never drops a pending lane.
    if (w_accept) begin
      hold_d = w_beat;
      pend_d = s_axis_tkeep & w_lane_en;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q     <= '0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
    end
  end

  // Beat payload is qualified by pend_q, so it needs no reset.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign m_axis_tvalid  = out_vld_q;
  assign m_axis_tagtime = out_q.tagtime;
  assign m_axis_channel = out_q.channel;
  assign m_axis_tlast   = out_last_q;

`ifdef SI_TAG_SERIALIZER_STATS_EN
  // --------------------------------------------------------------------------
  // Statistics: both counters wrap naturally at their width.
  // --------------------------------------------------------------------------
  logic [63:0] stat_out_q,  stat_out_d;
  logic [31:0] stat_filt_q, stat_filt_d;

  always_comb begin
    stat_out_d  = stat_out_q;
    stat_filt_d = stat_filt_q;
    if (out_vld_q && m_axis_tready) stat_out_d = stat_out_q + 64'd1;
    if (w_accept) stat_filt_d = stat_filt_q + f_popcount(s_axis_tkeep & ~w_lane_en);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_out_q  <= '0;
      stat_filt_q <= '0;
    end else begin
      stat_out_q  <= stat_out_d;
      stat_filt_q <= stat_filt_d;
    end
  end

  assign stat_tags_out      = stat_out_q;
  assign stat_tags_filtered = stat_filt_q;
`endif

endmodule

`default_nettype wire
